// File: rtl/multi_song_player_pkg.sv
// Shared definitions for the multi-song player.
// Holds the FSM state encodings (the 2-bit values also drive the state output),
// the loop_mode codes and the bit layout of a ROM word {note, dur}.
package multi_song_player_pkg;

  // FSM state encodings; ST_FETCH is internal and is reported as ST_PLAY.
  localparam logic [1:0] ST_STOP  = 2'b00;
  localparam logic [1:0] ST_PLAY  = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_FETCH = 2'b11;

  // loop_mode codes; 2'b11 falls through to play-once behaviour.
  localparam logic [1:0] MODE_ONCE    = 2'b00;
  localparam logic [1:0] MODE_REPEAT  = 2'b01;
  localparam logic [1:0] MODE_ADVANCE = 2'b10;

  // ROM word layout: {note, dur[3:0]}.
  localparam int unsigned DUR_W    = 4;
  localparam int unsigned DUR_LSB  = 0;
  localparam int unsigned NOTE_LSB = DUR_LSB + DUR_W;

endpackage

// File: rtl/multi_song_player_tick_gen.sv
// Duration tick divider.
// Counts 0..TICK_DIV-1 while hold_i is low and flags the last count with wrap_o.
//   clk, rst : clock, asynchronous active-high reset
//   clear_i  : synchronous clear of the count (wins over hold_i)
//   hold_i   : freeze the count
//   wrap_o   : high in the cycle the count rolls over to 0
module multi_song_player_tick_gen #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic hold_i,
  output logic wrap_o
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign wrap_o = !clear_i && !hold_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (!hold_i) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_song_player.sv
// Multi-song note sequencer.
// Walks a ROM of {note, dur} words per song, sounding each note for dur ticks, with
// play/pause/stop/next/prev buttons and play-once / repeat / advance-playlist modes.
//   clk, rst, en      : clock, asynchronous active-high reset, global enable
//   *_p               : single-cycle button pulses (priority stop > pause > play > next > prev)
//   loop_mode         : end-of-song behaviour
//   rom_addr/rom_data : {song_idx, note_idx} address, data valid one cycle later
//   note, state       : sounding note (0 outside PLAY), 00 STOP / 01 PLAY / 10 PAUSE
//   song_idx          : selected song; song_done pulses when a song ends
module multi_song_player
  import multi_song_player_pkg::*;
#(
  parameter int unsigned NUM_SONGS  = 4,
  parameter int unsigned SONG_DEPTH = 64,
  parameter int unsigned NOTE_W     = 5,
  parameter int unsigned TICK_DIV   = 12_500_000
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             en,
  input  logic                                             play_p,
  input  logic                                             pause_p,
  input  logic                                             stop_p,
  input  logic                                             next_p,
  input  logic                                             prev_p,
  input  logic [1:0]                                       loop_mode,
  output logic [$clog2(NUM_SONGS)+$clog2(SONG_DEPTH)-1:0]  rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]                          rom_data,
  output logic [NOTE_W-1:0]                                note,
  output logic [1:0]                                       state,
  output logic [$clog2(NUM_SONGS)-1:0]                     song_idx,
  output logic                                             song_done
);

  localparam int unsigned SongW = $clog2(NUM_SONGS);
  localparam int unsigned IdxW  = $clog2(SONG_DEPTH);
  localparam logic [SongW-1:0] LastSong = SongW'(NUM_SONGS - 1);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(SONG_DEPTH - 1);

  logic [1:0]        state_d, state_q;
  logic [SongW-1:0]  song_d, song_q;
  logic [IdxW-1:0]   idx_d, idx_q;
  logic [NOTE_W-1:0] note_d, note_q;
  logic [DUR_W-1:0]  dur_d, dur_q;
  logic [DUR_W-1:0]  dcnt_d, dcnt_q;
  logic              fetch_ph_d, fetch_ph_q;   // 0: address cycle, 1: capture cycle
  logic              stop_pend_d, stop_pend_q; // stop seen while fetching

  logic [DUR_W-1:0]  rom_dur;
  logic [NOTE_W-1:0] rom_note;
  logic              nav, tick_run, tick_clear, tick_wrap, note_last, song_end;

  function automatic logic [SongW-1:0] song_step(input logic [SongW-1:0] s, input logic up);
    if (up) begin
      return (s == LastSong) ? '0 : s + 1'b1;
    end
    return (s == '0) ? LastSong : s - 1'b1;
  endfunction

  assign rom_dur  = rom_data[DUR_LSB +: DUR_W];
  assign rom_note = rom_data[NOTE_LSB +: NOTE_W];

  // Navigation in PLAY only when no higher-priority pulse is present.
  assign nav = !stop_p && !pause_p && !play_p && (next_p || prev_p);

  // Ticks advance only on cycles where PLAY keeps playing the current note.
  assign tick_run   = en && (state_q == ST_PLAY) && !stop_p && !pause_p && !nav;
  assign tick_clear = en && ((state_q == ST_STOP) || (state_q == ST_FETCH));
  assign note_last  = ({1'b0, dcnt_q} + 1'b1) == {1'b0, dur_q};

  multi_song_player_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .clear_i (tick_clear),
    .hold_i  (!tick_run),
    .wrap_o  (tick_wrap)
  );

  always_comb begin
    state_d     = state_q;
    song_d      = song_q;
    idx_d       = idx_q;
    note_d      = note_q;
    dur_d       = dur_q;
    dcnt_d      = dcnt_q;
    fetch_ph_d  = fetch_ph_q;
    stop_pend_d = stop_pend_q;
    song_end    = 1'b0;

    if (en) begin
      unique case (state_q)
        ST_STOP: begin
          // stop/pause outrank play even though they do nothing here.
          if (!stop_p && !pause_p) begin
            if (play_p) begin
              state_d    = ST_FETCH;
              idx_d      = '0;
              fetch_ph_d = 1'b0;
            end else if (next_p || prev_p) begin
              song_d = song_step(song_q, next_p);
            end
          end
        end
        ST_FETCH: begin
          if (!fetch_ph_q) begin
            fetch_ph_d  = 1'b1;
            stop_pend_d = stop_pend_q || stop_p;
          end else begin
            fetch_ph_d  = 1'b0;
            stop_pend_d = 1'b0;
            note_d      = rom_note;
            dur_d       = rom_dur;
            dcnt_d      = '0;
            if (stop_pend_q || stop_p) begin
              state_d = ST_STOP;
              idx_d   = '0;
            end else if (rom_dur == '0) begin
              song_end = 1'b1;
            end else begin
              state_d = ST_PLAY;
            end
          end
        end
        ST_PLAY: begin
          if (stop_p) begin
            state_d = ST_STOP;
            idx_d   = '0;
          end else if (pause_p) begin
            state_d = ST_PAUSE;
          end else if (nav) begin
            song_d     = song_step(song_q, next_p);
            idx_d      = '0;
            state_d    = ST_FETCH;
            fetch_ph_d = 1'b0;
          end else if (tick_wrap) begin
            if (note_last) begin
              dcnt_d = '0;
              if (idx_q == LastIdx) begin
                song_end = 1'b1;
              end else begin
                idx_d      = idx_q + 1'b1;
                state_d    = ST_FETCH;
                fetch_ph_d = 1'b0;
              end
            end else begin
              dcnt_d = dcnt_q + 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (stop_p) begin
            state_d = ST_STOP;
            idx_d   = '0;
          end else if (pause_p || play_p) begin
            state_d = ST_PLAY;
          end
        end
        default: state_d = ST_STOP;
      endcase

      if (song_end) begin
        idx_d      = '0;
        fetch_ph_d = 1'b0;
        unique case (loop_mode)
          MODE_REPEAT:  state_d = ST_FETCH;
          MODE_ADVANCE: begin
            state_d = ST_FETCH;
            song_d  = song_step(song_q, 1'b1);
          end
          default:      state_d = ST_STOP;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_STOP;
      song_q      <= '0;
      idx_q       <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      dcnt_q      <= '0;
      fetch_ph_q  <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      song_q      <= song_d;
      idx_q       <= idx_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      dcnt_q      <= dcnt_d;
      fetch_ph_q  <= fetch_ph_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign state     = (state_q == ST_FETCH) ? ST_PLAY : state_q;
  assign note      = (state_q == ST_PLAY) ? note_q : '0;
  assign song_idx  = song_q;
  assign rom_addr  = {song_q, idx_q};
  assign song_done = song_end;

endmodule

// File: tb/tb_multi_song_player.sv
module tb_multi_song_player;

  localparam int NS = 4;
  localparam int SD = 8;
  localparam int NW = 5;
  localparam int TD = 4;
  localparam int SW = 2;
  localparam int IW = 3;

  localparam logic [4:0] P_STOP  = 5'b10000;
  localparam logic [4:0] P_PAUSE = 5'b01000;
  localparam logic [4:0] P_PLAY  = 5'b00100;
  localparam logic [4:0] P_NEXT  = 5'b00010;
  localparam logic [4:0] P_PREV  = 5'b00001;

  localparam int M_STOP  = 0;
  localparam int M_FETCH = 1;
  localparam int M_PLAY  = 2;
  localparam int M_PAUSE = 3;

  logic clk = 1'b0;
  logic rst, en, play_p, pause_p, stop_p, next_p, prev_p;
  logic [1:0] loop_mode;
  logic [SW+IW-1:0] rom_addr;
  logic [NW+3:0] rom_data;
  logic [NW-1:0] note;
  logic [1:0] state;
  logic [SW-1:0] song_idx;
  logic song_done;

  logic [NW+3:0] rom [NS*SD];

  int vectors = 0;
  int errors  = 0;

  // Reference model: position is tracked as cycles elapsed inside the current note.
  int m_st, m_song, m_idx, m_ph, m_el, m_note, m_dur;
  bit m_pend;

  logic [1:0] obs_state, exp_state;
  logic [NW-1:0] obs_note, exp_note;
  logic [SW-1:0] obs_song, exp_song;
  logic [SW+IW-1:0] obs_addr, exp_addr;
  logic obs_done, exp_done;

  multi_song_player #(
    .NUM_SONGS  (NS),
    .SONG_DEPTH (SD),
    .NOTE_W     (NW),
    .TICK_DIV   (TD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .play_p    (play_p),
    .pause_p   (pause_p),
    .stop_p    (stop_p),
    .next_p    (next_p),
    .prev_p    (prev_p),
    .loop_mode (loop_mode),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note      (note),
    .state     (state),
    .song_idx  (song_idx),
    .song_done (song_done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  task automatic model_reset();
    m_st = M_STOP; m_song = 0; m_idx = 0; m_ph = 0; m_el = 0; m_note = 0; m_dur = 0;
    m_pend = 0;
  endtask

  task automatic model_end_song();
    m_idx = 0;
    m_ph  = 0;
    if (loop_mode == 2'b01) begin
      m_st = M_FETCH;
    end else if (loop_mode == 2'b10) begin
      m_st = M_FETCH;
      m_song = (m_song + 1) % NS;
    end else begin
      m_st = M_STOP;
    end
  endtask

  task automatic model_step(output bit done);
    logic [NW+3:0] w;
    done = 0;
    if (!en) return;
    case (m_st)
      M_STOP: if (!stop_p && !pause_p) begin
        if (play_p) begin m_st = M_FETCH; m_idx = 0; m_ph = 0; end
        else if (next_p) m_song = (m_song + 1) % NS;
        else if (prev_p) m_song = (m_song + NS - 1) % NS;
      end
      M_FETCH: if (m_ph == 0) begin
        m_ph = 1;
        m_pend = m_pend || stop_p;
      end else begin
        w = rom[m_song * SD + m_idx];
        m_note = int'(w[NW+3:4]);
        m_dur  = int'(w[3:0]);
        m_el = 0;
        m_ph = 0;
        if (m_pend || stop_p) begin m_st = M_STOP; m_idx = 0; end
        else if (m_dur == 0) begin done = 1; model_end_song(); end
        else m_st = M_PLAY;
        m_pend = 0;
      end
      M_PLAY: if (stop_p) begin
        m_st = M_STOP; m_idx = 0;
      end else if (pause_p) begin
        m_st = M_PAUSE;
      end else if (!play_p && (next_p || prev_p)) begin
        m_song = next_p ? (m_song + 1) % NS : (m_song + NS - 1) % NS;
        m_idx = 0; m_st = M_FETCH; m_ph = 0;
      end else begin
        m_el++;
        if (m_el == m_dur * TD) begin
          if (m_idx == SD - 1) begin done = 1; model_end_song(); end
          else begin m_idx++; m_st = M_FETCH; m_ph = 0; end
        end
      end
      default: if (stop_p) begin
        m_st = M_STOP; m_idx = 0;
      end else if (pause_p || play_p) begin
        m_st = M_PLAY;
      end
    endcase
  endtask

  // One clock: sample DUT and model outputs, step the model, cross the edge.
  task automatic advance();
    bit d;
    #1;
    obs_state = state; obs_note = note; obs_song = song_idx; obs_addr = rom_addr;
    obs_done = song_done;
    exp_state = (m_st == M_STOP) ? 2'b00 : (m_st == M_PAUSE) ? 2'b10 : 2'b01;
    exp_note  = (m_st == M_PLAY) ? NW'(m_note) : '0;
    exp_song  = SW'(m_song);
    exp_addr  = (SW + IW)'(m_song * SD + m_idx);
    model_step(d);
    exp_done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [4:0] p);
    {stop_p, pause_p, play_p, next_p, prev_p} = p;
    advance();
    {stop_p, pause_p, play_p, next_p, prev_p} = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; loop_mode = 2'b00;
    {stop_p, pause_p, play_p, next_p, prev_p} = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors += 5;
    if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    if (note !== '0) begin errors++; $display("FAIL reset_note: got %0d want 0", note); end
    if (song_idx !== '0) begin errors++; $display("FAIL reset_song: got %0d want 0", song_idx); end
    if (rom_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
    if (song_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0d want 0", song_done); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    int n3 = 0, n5 = 0, dn = 0;
    loop_mode = 2'b00;
    pulse(P_PLAY);
    repeat (25) begin
      advance();
      if (obs_state == 2'b01 && obs_note == 5'd3) n3++;
      if (obs_state == 2'b01 && obs_note == 5'd5) n5++;
      if (obs_done) dn++;
    end
    vectors += 5;
    if (n3 != 8) begin errors++; $display("FAIL basic_note3_cycles: got %0d want 8", n3); end
    if (n5 != 4) begin errors++; $display("FAIL basic_note5_cycles: got %0d want 4", n5); end
    if (dn != 1) begin errors++; $display("FAIL basic_song_done: got %0d want 1", dn); end
    if (state !== 2'b00) begin errors++; $display("FAIL basic_end_state: got %0d want 0", state); end
    if (note !== '0) begin errors++; $display("FAIL basic_end_note: got %0d want 0", note); end
  endtask

  task automatic test_pause();
    int n = 0, guard = 0, bad = 0;
    pulse(P_PLAY);
    while (n < 5 && guard < 40) begin
      advance(); guard++;
      if (obs_state == 2'b01 && obs_note == 5'd3) n++;
    end
    vectors++;
    if (n != 5) begin errors++; $display("FAIL pause_lead: got %0d want 5", n); end
    pulse(P_PAUSE);
    repeat (20) begin
      advance();
      if (obs_state !== 2'b10 || obs_note !== '0) bad++;
    end
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL pause_hold: got %0d bad cycles want 0", bad); end
    pulse(P_PLAY);
    n = 0;
    repeat (20) begin
      advance();
      if (obs_state == 2'b01 && obs_note == 5'd3) n++;
    end
    vectors += 2;
    if (n != 3) begin errors++; $display("FAIL pause_resume: got %0d want 3", n); end
    if (state !== 2'b00) begin errors++; $display("FAIL pause_end_state: got %0d want 0", state); end
  endtask

  task automatic test_playlist();
    int guard = 0;
    bit seen = 0;
    pulse(P_PREV);
    vectors++;
    if (song_idx !== 2'd3) begin errors++; $display("FAIL nav_prev_wrap: got %0d want 3", song_idx); end
    pulse(P_NEXT);
    vectors++;
    if (song_idx !== 2'd0) begin errors++; $display("FAIL nav_next_wrap: got %0d want 0", song_idx); end
    pulse(P_PREV);
    vectors++;
    if (rom_addr !== 5'b11000) begin errors++; $display("FAIL nav_addr: got %0d want 24", rom_addr); end
    loop_mode = 2'b10;
    pulse(P_PLAY);
    while (!seen && guard < 40) begin
      advance(); guard++;
      seen = obs_done;
    end
    vectors += 5;
    if (!seen) begin errors++; $display("FAIL adv_done: got 0 want 1 within 40 cycles"); end
    if (song_idx !== 2'd0) begin errors++; $display("FAIL adv_song: got %0d want 0", song_idx); end
    if (state !== 2'b01) begin errors++; $display("FAIL adv_state: got %0d want 1", state); end
    if (note !== '0) begin errors++; $display("FAIL adv_note: got %0d want 0", note); end
    if (rom_addr !== '0) begin errors++; $display("FAIL adv_addr: got %0d want 0", rom_addr); end
  endtask

  task automatic test_stop_pause();
    int guard = 0;
    loop_mode = 2'b00;
    pulse(P_STOP);  // arrives while fetching
    repeat (2) advance();
    vectors++;
    if (state !== 2'b00) begin errors++; $display("FAIL fetch_stop: got %0d want 0", state); end
    pulse(P_PLAY);
    while (note !== 5'd3 && guard < 10) begin advance(); guard++; end
    stop_p = 1'b1; pause_p = 1'b1;
    advance();
    stop_p = 1'b0; pause_p = 1'b0;
    vectors += 2;
    if (state !== 2'b00) begin errors++; $display("FAIL stop_over_pause_state: got %0d want 0", state); end
    if (note !== '0) begin errors++; $display("FAIL stop_over_pause_note: got %0d want 0", note); end
  endtask

  task automatic test_reset_mid();
    int guard = 0, n = 0, bad = 0;
    pulse(P_PLAY);
    while (note !== 5'd3 && guard < 10) begin advance(); guard++; end
    advance(); advance();
    rst = 1'b1;
    #1;
    vectors += 5;
    if (state !== 2'b00) begin errors++; $display("FAIL rstmid_state: got %0d want 0", state); end
    if (note !== '0) begin errors++; $display("FAIL rstmid_note: got %0d want 0", note); end
    if (song_idx !== '0) begin errors++; $display("FAIL rstmid_song: got %0d want 0", song_idx); end
    if (rom_addr !== '0) begin errors++; $display("FAIL rstmid_addr: got %0d want 0", rom_addr); end
    if (song_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %0d want 0", song_done); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    pulse(P_PLAY);
    guard = 0;
    while (n < 2 && guard < 10) begin
      advance(); guard++;
      if (obs_state == 2'b01 && obs_note == 5'd3) n++;
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_p = (i == 4);
      advance();
      if (obs_state !== 2'b01 || obs_note !== 5'd3) bad++;
    end
    next_p = 1'b0;
    en = 1'b1;
    vectors += 2;
    if (bad != 0) begin errors++; $display("FAIL en_freeze: got %0d bad cycles want 0", bad); end
    if (song_idx !== '0) begin errors++; $display("FAIL en_drop_pulse: got %0d want 0", song_idx); end
    repeat (20) begin
      advance();
      if (obs_state == 2'b01 && obs_note == 5'd3) n++;
    end
    vectors++;
    if (n != 8) begin errors++; $display("FAIL en_note_total: got %0d want 8", n); end
  endtask

  task automatic test_random();
    for (int s = 1; s < NS; s++) begin
      for (int k = 0; k < SD; k++) begin
        int d;
        d = (s != 2 && $urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
        rom[s * SD + k] = {NW'($urandom_range(0, 31)), 4'(d)};
      end
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      stop_p  = ($urandom_range(0, 59) == 0);
      pause_p = ($urandom_range(0, 24) == 0);
      play_p  = ($urandom_range(0, 11) == 0);
      next_p  = ($urandom_range(0, 29) == 0);
      prev_p  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 199) == 0) loop_mode = 2'($urandom_range(0, 3));
      advance();
      vectors += 5;
      if (obs_state !== exp_state) begin
        errors++; $display("FAIL rand_state cyc %0d: got %0d want %0d", i, obs_state, exp_state);
      end
      if (obs_note !== exp_note) begin
        errors++; $display("FAIL rand_note cyc %0d: got %0d want %0d", i, obs_note, exp_note);
      end
      if (obs_song !== exp_song) begin
        errors++; $display("FAIL rand_song cyc %0d: got %0d want %0d", i, obs_song, exp_song);
      end
      if (obs_addr !== exp_addr) begin
        errors++; $display("FAIL rand_addr cyc %0d: got %0d want %0d", i, obs_addr, exp_addr);
      end
      if (obs_done !== exp_done) begin
        errors++; $display("FAIL rand_done cyc %0d: got %0d want %0d", i, obs_done, exp_done);
      end
    end
    {stop_p, pause_p, play_p, next_p, prev_p} = '0;
    en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NS * SD; i++) rom[i] = '0;
    rom[0] = {5'd3, 4'd2};
    rom[1] = {5'd5, 4'd1};
    rom[2] = {5'd0, 4'd0};
    rom[3 * SD + 0] = {5'd7, 4'd1};
    rom[3 * SD + 1] = {5'd0, 4'd0};
    model_reset();
    test_reset();
    test_basic();
    test_pause();
    test_playlist();
    test_stop_pause();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/multi_song_player.md
MULTI_SONG_PLAYER -- requirements
Module: multi_song_player

Interface
REQ-001 Parameter NUM_SONGS, default 4, number of songs in the playlist (2..16).
REQ-002 Parameter SONG_DEPTH, default 64, note slots per song, power of two.
REQ-003 Parameter NOTE_W, default 5, width of a note code; code 0 means rest.
REQ-004 Parameter TICK_DIV, default 12_500_000, clk cycles per duration tick (>=2).
REQ-005 Port clk, input, 1, system clock; single clock domain.
REQ-006 Port rst, input, 1, reset; asynchronous, active-high.
REQ-007 Port en, input, 1, global enable; when 0, all registers hold.
REQ-008 Port play_p / pause_p / stop_p / next_p / prev_p, input, 1 each, single-cycle debounced button pulses.
REQ-009 Port loop_mode, input, 2, 00 play once, 01 repeat song, 10 advance playlist, 11 treated as 00.
REQ-010 Port rom_addr, output, $clog2(NUM_SONGS)+$clog2(SONG_DEPTH), {song_idx, note_idx}.
REQ-011 Port rom_data, input, NOTE_W+4, {note, dur[3:0]}, valid exactly 1 cycle after rom_addr changes.
REQ-012 Port note, output, NOTE_W, note currently sounding; 0 when not in PLAY.
REQ-013 Port state, output, 2, 00 STOP, 01 PLAY, 10 PAUSE.
REQ-014 Port song_idx, output, $clog2(NUM_SONGS), selected song.
REQ-015 Port song_done, output, 1, one-cycle pulse when a song ends.

Function
REQ-016 FSM states STOP, FETCH, PLAY, PAUSE; state output maps FETCH to 01.
REQ-017 STOP: play_p -> FETCH with note_idx=0; next_p/prev_p change song_idx modulo NUM_SONGS (wrap both ways).
REQ-018 FETCH: lasts exactly 2 cycles (address, then capture rom_data); then PLAY with tick counter and dur counter cleared.
REQ-019 PLAY: note = captured note; tick counter counts 0..TICK_DIV-1; on wrap dur counter increments; when dur counter reaches captured dur, note_idx increments and FSM enters FETCH.
REQ-020 End of song: captured dur==0 or note_idx wraps past SONG_DEPTH-1; song_done pulses in that cycle.
REQ-021 At end of song: mode 00 -> STOP, note_idx=0; mode 01 -> FETCH note_idx=0 same song; mode 10 -> FETCH note_idx=0, song_idx+1 modulo NUM_SONGS.
REQ-022 PLAY: pause_p -> PAUSE; stop_p -> STOP, note_idx=0; next_p/prev_p -> change song_idx, note_idx=0, FETCH.
REQ-023 PAUSE: note=0, tick/dur counters and note_idx frozen; pause_p or play_p -> PLAY resuming mid-note; stop_p -> STOP.
REQ-024 Simultaneous pulses priority: stop_p > pause_p > play_p > next_p > prev_p.
REQ-025 Button pulses arriving in FETCH are honoured after FETCH completes only for stop_p (FETCH aborts to STOP); others ignored.
REQ-026 en=0 freezes FSM, counters and outputs; pulses during en=0 are dropped.

Reset
REQ-027 On rst: state STOP, song_idx 0, note_idx 0, counters 0, note 0, song_done 0, rom_addr 0.
REQ-028 Reset mid-PLAY takes effect immediately (asynchronous) and releases into STOP.

Structure
REQ-029 State encodings, loop_mode codes and rom_data field offsets live in the shared player package.
REQ-030 One sub-module, tick_gen (parametrised TICK_DIV divider with clear and hold inputs), is instantiated; the rest is one FSM.

Verification
REQ-031 TICK_DIV=4, song0 = {(3,2),(5,1),(0,0)}, mode 00, play_p -> note 3 for 8 cycles, note 5 for 4, song_done, STOP.
REQ-032 Same song, pause_p after 5 PLAY cycles, hold 20, play_p -> note 3 resumes for remaining 3 cycles.
REQ-033 Mode 10, NUM_SONGS=4, song_idx=3 ends -> song_idx 0, FETCH, note_idx 0.
REQ-034 STOP, prev_p at song_idx 0 -> song_idx 3; next_p -> 0.
REQ-035 stop_p and pause_p same cycle in PLAY -> STOP, note 0.
REQ-036 rst asserted mid-note -> all outputs zero same cycle; en=0 for 10 cycles -> note and counters unchanged.
